// File: rtl/lfsr_trng_core_pkg.sv
// Shared constants and the Galois LFSR step for the TRNG core.
package lfsr_trng_core_pkg;

    localparam int LFSR_W = 32;

    // x^32 + x^22 + x^2 + x + 1, right-shifting Galois form
    localparam logic [LFSR_W-1:0] LFSR_TAPS_DEFAULT = 32'h80200003;
    // Reset state and replacement for an all-zero mix; must be nonzero
    localparam logic [LFSR_W-1:0] LFSR_SEED_DEFAULT = 32'h00000001;

    // One Galois step: shift right, fold the taps in when a one drops out
    function automatic logic [LFSR_W-1:0] lfsr_step(
        input logic [LFSR_W-1:0] s,
        input logic [LFSR_W-1:0] taps
    );
        lfsr_step = s[0] ? ((s >> 1) ^ taps) : (s >> 1);
    endfunction

endpackage

// File: rtl/lfsr_trng_ram.sv
// Single-port capture RAM: registered read, read-before-write on collision,
// out-of-range writes dropped and out-of-range reads return zero.
module lfsr_trng_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int RAM_DEPTH  = 100
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_i,
    input  logic                  rd_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] data_o
);

    localparam int IDX_W = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem_q [RAM_DEPTH];
    logic [DATA_WIDTH-1:0] data_d, data_q;
    logic                  in_range;
    logic [IDX_W-1:0]      idx;

    // Address decode shared by both ports
    always_comb begin
        in_range = (addr_i < ADDR_WIDTH'(RAM_DEPTH));
        idx      = addr_i[IDX_W-1:0];
    end

    // Storage is never cleared; writes are held off while reset is asserted
    always_ff @(posedge clk) begin
        if (rst && we_i && in_range) begin
            mem_q[idx] <= wdata_i;
        end
    end

    // Read mux sees the pre-edge array contents, giving read-before-write
    always_comb begin
        data_d = data_q;
        if (rd_i) begin
            data_d = in_range ? mem_q[idx] : '0;
        end
    end

    // Registered read data
    always_ff @(posedge clk) begin
        if (!rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/lfsr_trng_core.sv
// LFSR random source re-seeded from a free-running cycle counter at the start
// of every request run, with a capture RAM for the produced words.
// n and DATA_WIDTH must both equal LFSR_W from the package.
module lfsr_trng_core
    import lfsr_trng_core_pkg::*;
#(
    parameter int              n          = 32,
    parameter int              DATA_WIDTH = 32,
    parameter int              ADDR_WIDTH = 32,
    parameter int              RAM_DEPTH  = 100,
    parameter logic [DATA_WIDTH-1:0] LFSR_TAPS = LFSR_TAPS_DEFAULT,
    parameter logic [DATA_WIDTH-1:0] LFSR_SEED = LFSR_SEED_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  request,
    input  logic                  we_i,
    input  logic                  rd_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    output logic [DATA_WIDTH-1:0] rnd,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [n-1:0]          count
);

    logic [n-1:0]          count_d, count_q;
    logic [DATA_WIDTH-1:0] lfsr_d, lfsr_q;
    logic [DATA_WIDTH-1:0] rnd_d, rnd_q;
    logic                  req_d, req_q;
    logic [DATA_WIDTH-1:0] mix;
    logic [DATA_WIDTH-1:0] src;

    // Next state: counter always runs; LFSR steps only while request is high,
    // mixing in the counter on the first cycle of each run
    always_comb begin
        count_d = count_q + 1'b1;
        req_d   = request;
        lfsr_d  = lfsr_q;
        rnd_d   = rnd_q;
        mix     = lfsr_q ^ count_q;
        if (mix == '0) begin
            mix = LFSR_SEED;    // keep the register out of the lock-up state
        end
        src = req_q ? lfsr_q : mix;
        if (request) begin
            lfsr_d = lfsr_step(src, LFSR_TAPS);
            rnd_d  = lfsr_d;
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
            lfsr_q  <= LFSR_SEED;
            rnd_q   <= '0;
            req_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            lfsr_q  <= lfsr_d;
            rnd_q   <= rnd_d;
            req_q   <= req_d;
        end
    end

    assign rnd   = rnd_q;
    assign count = count_q;

    // Capture buffer stores the pre-edge rnd
    lfsr_trng_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .RAM_DEPTH  (RAM_DEPTH)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (we_i),
        .rd_i    (rd_i),
        .addr_i  (addr_i),
        .wdata_i (rnd_q),
        .data_o  (data_o)
    );

endmodule

// File: tb/tb_lfsr_trng_core.sv
// Self-checking bench for lfsr_trng_core against an integer reference model.
module tb_lfsr_trng_core;

    localparam int unsigned TAPS  = 32'h80200003;
    localparam int unsigned SEED  = 32'h00000001;
    localparam int unsigned DEPTH = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic        request;
    logic        we_i;
    logic        rd_i;
    logic [31:0] addr_i;
    logic [31:0] rnd;
    logic [31:0] data_o;
    logic [31:0] count;

    int checks   = 0;
    int failures = 0;

    // reference model state
    int unsigned m_count, m_lfsr, m_rnd, m_data;
    bit          m_req;
    int unsigned m_mem [DEPTH];
    logic [31:0] rb [DEPTH];

    lfsr_trng_core dut (
        .clk     (clk),
        .rst     (rst),
        .request (request),
        .we_i    (we_i),
        .rd_i    (rd_i),
        .addr_i  (addr_i),
        .rnd     (rnd),
        .data_o  (data_o),
        .count   (count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    function automatic int unsigned ref_step(input int unsigned s);
        if (s % 2 == 1) return (s / 2) ^ TAPS;
        return s / 2;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // one clock: drive at negedge, advance the model at the edge, compare at next negedge
    task automatic tick(input bit r, input bit rq, input bit we, input bit rd, input logic [31:0] a);
        int unsigned s;
        int unsigned old_rnd;
        rst = r; request = rq; we_i = we; rd_i = rd; addr_i = a;
        @(posedge clk);
        if (!r) begin
            m_count = 0; m_rnd = 0; m_data = 0; m_lfsr = SEED; m_req = 0;
        end else begin
            old_rnd = m_rnd;
            if (rd) m_data = (a < DEPTH) ? m_mem[a] : 0;
            if (we && a < DEPTH) m_mem[a] = old_rnd;
            if (rq) begin
                s = m_req ? m_lfsr : (m_lfsr ^ m_count);
                if (s == 0) s = SEED;
                m_lfsr = ref_step(s);
                m_rnd  = m_lfsr;
            end
            m_req   = rq;
            m_count = m_count + 1;
        end
        @(negedge clk);
        check("count",  count,  m_count);
        check("rnd",    rnd,    m_rnd);
        check("data_o", data_o, m_data);
    endtask

    initial begin
        bit distinct;
        rst = 1'b0; request = 1'b0; we_i = 1'b0; rd_i = 1'b0; addr_i = '0;
        @(negedge clk);

        // reset held two cycles
        tick(0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0);
        check("reset_count", count, 32'd0);
        check("reset_rnd", rnd, 32'd0);

        // first request at count 0
        tick(1, 1, 0, 0, 0);
        check("seq0", rnd, 32'h80200003);
        check("cnt1", count, 32'd1);
        tick(1, 1, 0, 0, 0);
        check("seq1", rnd, 32'hC0300002);
        tick(1, 1, 0, 0, 0);
        check("seq2", rnd, 32'h60180001);
        check("cnt3", count, 32'd3);
        for (int i = 0; i < 3; i++) tick(1, 0, 0, 0, 0);
        check("hold", rnd, 32'h60180001);

        // zero-mix fallback: first request lands at count 1 with lfsr = SEED
        tick(0, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0);
        tick(1, 1, 0, 0, 0);
        check("zero_mix", rnd, 32'h80200003);

        // capture then readback
        for (int i = 0; i < int'(DEPTH); i++) tick(1, 1, 1, 0, i);
        for (int i = 0; i < int'(DEPTH); i++) begin
            tick(1, 0, 0, 1, i);
            rb[i] = data_o;
        end
        distinct = 1'b1;
        for (int i = 0; i < int'(DEPTH); i++)
            for (int j = i + 1; j < int'(DEPTH); j++)
                if (rb[i] === rb[j]) distinct = 1'b0;
        check("distinct", {31'd0, distinct}, 32'd1);

        // bounds
        tick(1, 1, 1, 0, 100);
        tick(1, 0, 0, 1, 100);
        check("oob_rd100", data_o, 32'd0);
        tick(1, 0, 0, 1, 7);
        tick(1, 0, 0, 1, 32'hFFFFFFFF);
        check("oob_rdmax", data_o, 32'd0);

        // collision on address 5: old word first, new word after
        tick(1, 1, 0, 0, 0);
        tick(1, 0, 1, 1, 5);
        check("coll_old", data_o, rb[5]);
        tick(1, 0, 0, 1, 5);

        // randomized traffic, a mid-run reset, then more traffic
        for (int i = 0; i < 150; i++)
            tick(1, ($urandom % 4) != 0, ($urandom % 4) == 0, ($urandom % 3) == 0,
                 $urandom_range(0, 109));
        tick(0, 1, 0, 0, 0);
        for (int i = 0; i < 100; i++)
            tick(1, ($urandom % 4) != 0, ($urandom % 4) == 0, ($urandom % 3) == 0,
                 $urandom_range(0, 109));

        // counter wrap
        force dut.count_q = 32'hFFFFFFFF;
        #1;
        release dut.count_q;
        #1;
        check("cnt_forced", count, 32'hFFFFFFFF);
        m_count = 32'hFFFFFFFF;
        tick(1, 0, 0, 0, 0);
        check("cnt_wrap", count, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
